// File: rtl/vram_arbiter_pkg.sv
// Shared video definitions: VRAM geometry defaults and the arbiter state encoding.
package vram_arbiter_pkg;

    localparam int unsigned VRAM_ADDR_W    = 16;
    localparam int unsigned VRAM_DATA_W    = 16;
    localparam int unsigned DEF_LINE_WORDS = 160;
    localparam int unsigned DEF_LINE_W     = 10;
    localparam int unsigned DEF_CPU_SLOT   = 4;
    localparam int unsigned LB_ADDR_W      = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } vram_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: streams one scanline per fetch_start into a ping-pong
// line buffer while guaranteeing the CPU port one RAM slot every CPU_SLOT cycles.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = VRAM_ADDR_W,
    parameter int unsigned DATA_W     = VRAM_DATA_W,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned LINE_W     = DEF_LINE_W,
    parameter int unsigned CPU_SLOT   = DEF_CPU_SLOT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    fb_base,
    input  logic                 fetch_start,
    input  logic [LINE_W-1:0]    fetch_line,
    output logic                 fetch_done,
    output logic                 overrun,
    output logic                 lb_we,
    output logic                 lb_bank,
    output logic [LB_ADDR_W-1:0] lb_addr,
    output logic [DATA_W-1:0]    lb_data,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata,
    input  logic                 cpu_valid,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic                 cpu_ready,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_rvalid
);

    localparam int unsigned WORD_W = LB_ADDR_W;
    localparam int unsigned SLOT_W = (CPU_SLOT > 1) ? $clog2(CPU_SLOT) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CPU_SLOT - 1);

    vram_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic                bank_q, bank_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                overrun_q, overrun_d;
    logic                lb_we_q, lb_we_d;
    logic [WORD_W-1:0]   lb_addr_q, lb_addr_d;
    logic                fetch_done_q, fetch_done_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;

    logic                cpu_grant_c;
    logic                fetch_issue_c;
    logic                last_issue_c;
    logic [ADDR_W-1:0]   start_addr_c;

    // Line start address wraps modulo 2^ADDR_W.
    assign start_addr_c = fb_base + ADDR_W'(ADDR_W'(fetch_line) * ADDR_W'(LINE_WORDS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            line_addr_q  <= '0;
            bank_q       <= 1'b0;
            word_q       <= '0;
            slot_q       <= '0;
            overrun_q    <= 1'b0;
            lb_we_q      <= 1'b0;
            lb_addr_q    <= '0;
            fetch_done_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            bank_q       <= bank_d;
            word_q       <= word_d;
            slot_q       <= slot_d;
            overrun_q    <= overrun_d;
            lb_we_q      <= lb_we_d;
            lb_addr_q    <= lb_addr_d;
            fetch_done_q <= fetch_done_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    // Grant, RAM port mux and next-state logic.
    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        bank_d       = bank_q;
        word_d       = word_q;
        slot_d       = slot_q;
        overrun_d    = overrun_q;

        cpu_ready     = (state_q == ST_IDLE) || (slot_q == LAST_SLOT);
        cpu_grant_c   = cpu_valid && cpu_ready;
        fetch_issue_c = (state_q == ST_FETCH) && !cpu_grant_c;
        last_issue_c  = fetch_issue_c && (word_q == LAST_WORD);

        ram_en    = cpu_grant_c || fetch_issue_c;
        ram_we    = cpu_grant_c && cpu_we;
        ram_addr  = cpu_grant_c ? cpu_addr : (line_addr_q + ADDR_W'(word_q));
        ram_wdata = cpu_wdata;

        // A read issued in the same cycle as a restart belongs to the aborted fetch.
        lb_we_d      = fetch_issue_c && !fetch_start;
        lb_addr_d    = fetch_issue_c ? word_q : lb_addr_q;
        fetch_done_d = last_issue_c && !fetch_start;
        cpu_rvalid_d = cpu_grant_c && !cpu_we;
        cpu_rdata_d  = cpu_rvalid_q ? ram_rdata : cpu_rdata_q;

        if (state_q == ST_FETCH) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
            if (fetch_issue_c) begin
                word_d = word_q + WORD_W'(1);
            end
            if (last_issue_c) begin
                state_d = ST_IDLE;
            end
        end

        if (fetch_start) begin
            if (state_q == ST_FETCH) begin
                overrun_d = 1'b1;
            end
            state_d     = ST_FETCH;
            line_addr_d = start_addr_c;
            bank_d      = fetch_line[0];
            word_d      = '0;
            slot_d      = '0;
        end
    end

    assign fetch_done = fetch_done_q;
    assign overrun    = overrun_q;
    assign lb_we      = lb_we_q;
    assign lb_bank    = bank_q;
    assign lb_addr    = lb_addr_q;
    assign lb_data    = ram_rdata;
    assign cpu_rvalid = cpu_rvalid_q;
    // Read data arrives from the RAM in the response cycle and is held afterwards.
    assign cpu_rdata  = cpu_rvalid_q ? ram_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: CPU vector table plus scanline fetch sequences.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] fb_base;
    logic        fetch_start;
    logic [9:0]  fetch_line;
    logic        fetch_done;
    logic        overrun;
    logic        lb_we;
    logic        lb_bank;
    logic [7:0]  lb_addr;
    logic [15:0] lb_data;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        cpu_valid;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    vram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .fb_base     (fb_base),
        .fetch_start (fetch_start),
        .fetch_line  (fetch_line),
        .fetch_done  (fetch_done),
        .overrun     (overrun),
        .lb_we       (lb_we),
        .lb_bank     (lb_bank),
        .lb_addr     (lb_addr),
        .lb_data     (lb_data),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .cpu_valid   (cpu_valid),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: unwritten words read back as their own address.
    logic [15:0] mem [0:65535];
    bit          written [0:65535];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= written[ram_addr] ? mem[ram_addr] : ram_addr;
            end
        end
    end

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        bank;
        logic        done;
        logic [31:0] cyc;
    } lb_ev_t;

    lb_ev_t lbq[$];

    always @(negedge clk) begin
        if (lb_we === 1'b1 || fetch_done === 1'b1)
            lbq.push_back('{addr: lb_addr, data: lb_data, bank: lb_bank,
                            done: fetch_done, cyc: 32'(cyc)});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare n recorded line-buffer writes starting at queue index first.
    task automatic expect_lines(input string name, input int first, input int n,
                                input logic [15:0] base, input logic bank,
                                input bit chk_cyc, input int cyc0);
        int bad = 0;
        lb_ev_t ev;
        for (int i = 0; i < n; i++) begin
            if (first + i >= lbq.size()) begin
                bad++;
            end else begin
                ev = lbq[first + i];
                if (ev.addr !== 8'(i) || ev.data !== base + 16'(i) || ev.bank !== bank ||
                    (chk_cyc && ev.cyc !== 32'(cyc0 + i)))
                    bad++;
            end
        end
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic check_done(input string name, input int exp_cyc);
        int n_done = 0;
        int dcyc = -1;
        for (int i = 0; i < lbq.size(); i++) begin
            if (lbq[i].done === 1'b1) begin
                n_done++;
                dcyc = int'(lbq[i].cyc);
            end
        end
        check({name, "_count"}, 32'(n_done), 32'd1);
        check({name, "_cycle"}, 32'(dcyc), 32'(exp_cyc));
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic rv, output logic [15:0] d);
        cpu_valid = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = a;
        tick();
        cpu_valid = 1'b0;
        @(negedge clk);
        rv = cpu_rvalid;
        d  = cpu_rdata;
        tick();
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_rvalid;
        logic [15:0] exp_rdata;
    } cpu_vec_t;

    cpu_vec_t vec [8];

    initial begin
        int t0;
        int bad;
        int k;
        logic granted;
        logic rv;
        logic [15:0] rd;

        vec[0] = '{1'b1, 16'h0042, 16'hBEEF, 1'b0, 16'h0000};
        vec[1] = '{1'b0, 16'h0042, 16'h0000, 1'b1, 16'hBEEF};
        vec[2] = '{1'b0, 16'h0007, 16'h0000, 1'b1, 16'h0007};
        vec[3] = '{1'b1, 16'hFFFF, 16'h5A5A, 1'b0, 16'h0000};
        vec[4] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h5A5A};
        vec[5] = '{1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000};
        vec[6] = '{1'b0, 16'h0100, 16'h0000, 1'b1, 16'h1234};
        vec[7] = '{1'b0, 16'h1320, 16'h0000, 1'b1, 16'h1320};

        reset       = 1'b1;
        fb_base     = 16'h1000;
        fetch_start = 1'b0;
        fetch_line  = 10'd0;
        cpu_valid   = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = 16'h0000;
        cpu_wdata   = 16'h0000;
        tick();
        tick();
        @(negedge clk);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_fetch_done", 32'(fetch_done), 32'd0);
        check("rst_lb_we", 32'(lb_we), 32'd0);
        check("rst_lb_addr", 32'(lb_addr), 32'd0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        tick();
        reset = 1'b0;
        tick();

        // CPU accesses in IDLE, one vector per transfer.
        for (int i = 0; i < 8; i++) begin
            cpu_valid = 1'b1;
            cpu_we    = vec[i].we;
            cpu_addr  = vec[i].addr;
            cpu_wdata = vec[i].wdata;
            @(negedge clk);
            check($sformatf("v%0d_ready", i), 32'(cpu_ready), 32'd1);
            check($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'd1);
            check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vec[i].we));
            check($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vec[i].addr));
            tick();
            cpu_valid = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_rvalid", i), 32'(cpu_rvalid), 32'(vec[i].exp_rvalid));
            if (vec[i].exp_rvalid)
                check($sformatf("v%0d_rdata", i), 32'(cpu_rdata), 32'(vec[i].exp_rdata));
            tick();
        end

        // Line 5, no CPU traffic.
        lbq.delete();
        fetch_line  = 10'd5;
        fetch_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check("t1_c0_ram_en", 32'(ram_en), 32'd0);
        tick();
        fetch_start = 1'b0;
        @(negedge clk);
        check("t1_first_addr", 32'(ram_addr), 32'h1320);
        check("t1_first_en", 32'(ram_en), 32'd1);
        repeat (170) tick();
        check("t1_nwords", 32'(lbq.size()), 32'd160);
        expect_lines("t1_words", 0, 160, 16'h1320, 1'b1, 1'b1, t0 + 2);
        check_done("t1_done", t0 + 161);
        check("t1_overrun", 32'(overrun), 32'd0);

        // fetch_start and CPU write in the same IDLE cycle.
        lbq.delete();
        fetch_line  = 10'd0;
        fetch_start = 1'b1;
        cpu_valid   = 1'b1;
        cpu_we      = 1'b1;
        cpu_addr    = 16'h9000;
        cpu_wdata   = 16'h7777;
        t0 = cyc;
        @(negedge clk);
        check("t6_ready", 32'(cpu_ready), 32'd1);
        check("t6_cpu_addr", 32'(ram_addr), 32'h9000);
        check("t6_cpu_we", 32'(ram_we), 32'd1);
        tick();
        fetch_start = 1'b0;
        cpu_valid   = 1'b0;
        @(negedge clk);
        check("t6_fetch_addr", 32'(ram_addr), 32'h1000);
        check("t6_fetch_we", 32'(ram_we), 32'd0);
        repeat (170) tick();
        expect_lines("t6_words", 0, 160, 16'h1000, 1'b0, 1'b1, t0 + 2);
        check_done("t6_done", t0 + 161);
        cpu_read(16'h9000, rv, rd);
        check("t6_readback", {15'd0, rv, rd}, {15'd0, 1'b1, 16'h7777});

        // Continuous CPU writes during a fetch of line 0.
        lbq.delete();
        fetch_line  = 10'd0;
        fetch_start = 1'b1;
        t0 = cyc;
        tick();
        fetch_start = 1'b0;
        cpu_valid   = 1'b1;
        cpu_we      = 1'b1;
        k           = 0;
        cpu_addr    = 16'h8000;
        cpu_wdata   = 16'hA000;
        bad         = 0;
        for (int rel = 1; rel <= 213; rel++) begin
            @(negedge clk);
            if (cpu_ready !== ((rel % 4) == 0)) bad++;
            granted = cpu_ready;
            tick();
            if (granted) begin
                k++;
                cpu_addr  = 16'h8000 + 16'(k);
                cpu_wdata = 16'hA000 + 16'(k);
            end
        end
        cpu_valid = 1'b0;
        check("t2_ready_pattern", 32'(bad), 32'd0);
        check("t2_grants", 32'(k), 32'd53);
        repeat (10) tick();
        check("t2_nwords", 32'(lbq.size()), 32'd160);
        expect_lines("t2_words", 0, 160, 16'h1000, 1'b0, 1'b0, 0);
        check_done("t2_done", t0 + 214);
        bad = 0;
        for (int j = 0; j < 53; j++) begin
            cpu_read(16'h8000 + 16'(j), rv, rd);
            if (rv !== 1'b1 || rd !== 16'hA000 + 16'(j)) bad++;
        end
        check("t2_readback", 32'(bad), 32'd0);

        // Restart 50 cycles into a fetch of line 3 with line 6.
        lbq.delete();
        fetch_line  = 10'd3;
        fetch_start = 1'b1;
        t0 = cyc;
        tick();
        fetch_start = 1'b0;
        repeat (49) tick();
        fetch_line  = 10'd6;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        @(negedge clk);
        check("t4_overrun_set", 32'(overrun), 32'd1);
        check("t4_no_abort_we", 32'(lb_we), 32'd0);
        check("t4_restart_addr", 32'(ram_addr), 32'h13C0);
        repeat (180) tick();
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
        check("t4_nwords", 32'(lbq.size()), 32'd209);
        expect_lines("t4_old", 0, 49, 16'h11E0, 1'b1, 1'b1, t0 + 2);
        expect_lines("t4_new", 49, 160, 16'h13C0, 1'b0, 1'b1, t0 + 52);
        check_done("t4_done", t0 + 211);

        // Reset while word 80 of line 2 is being read.
        lbq.delete();
        fetch_line  = 10'd2;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        repeat (80) tick();
        reset = 1'b1;
        @(negedge clk);
        check("t5_word80_addr", 32'(ram_addr), 32'h1190);
        tick();
        @(negedge clk);
        check("t5_ram_en", 32'(ram_en), 32'd0);
        check("t5_lb_we", 32'(lb_we), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_cpu_rdata", 32'(cpu_rdata), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        lbq.delete();
        fetch_line  = 10'd1;
        fetch_start = 1'b1;
        t0 = cyc;
        tick();
        fetch_start = 1'b0;
        repeat (170) tick();
        check("t5_nwords", 32'(lbq.size()), 32'd160);
        expect_lines("t5_words", 0, 160, 16'h10A0, 1'b1, 1'b1, t0 + 2);
        check_done("t5_done", t0 + 161);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
